// File: rtl/fetch_queue_if.sv
// Squash broadcast from the back end; only valid is consumed by the fetch queue.
interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch-to-decode buffer: one-cycle transit, one push and one pop per cycle.
// fetch_i_ready keeps a slot for the in-flight beat; dec_o is valid/ready, squash flushes.
package fetch_queue_pkg;
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bp_t;

  typedef struct packed {
    logic [31:0] pc;
    bp_t         bp;
    logic [31:0] data;
  } fetch_data_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  fetch_data_t                fetch_i,
  input  logic                       fetch_i_valid,
  output logic                       fetch_i_ready,
  output fetch_data_t                dec_o,
  output logic                       dec_o_valid,
  input  logic                       dec_o_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow,
  squash_if.slave                    squash_io
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(DEPTH - 2);

  fetch_data_t      mem_q [DEPTH];
  fetch_data_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic flush;
  logic push;
  logic pop;
  logic drop;

  // Non-power-of-two depths need an explicit wrap rather than natural rollover.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    flush = squash_io.valid;
    pop   = dec_o_valid && dec_o_ready && !flush;
    push  = fetch_i_valid && !flush && ((count_q < CNT_FULL) || pop);
    drop  = fetch_i_valid && !flush && (count_q == CNT_FULL) && !pop;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    if (push) begin
      mem_d[wr_ptr_q] = fetch_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Squash empties the queue but leaves the storage and the sticky error alone.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    dec_o         = mem_q[rd_ptr_q];
    dec_o_valid   = (count_q != '0);
    fetch_i_ready = (count_q <= CNT_READY);
    occupancy     = count_q;
    overflow      = overflow_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table on DEPTH=4, wrap stress on DEPTH=3.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_data_t f4, d4o;
  logic        v4, r4, dv4, dr4, ov4;
  logic [2:0]  occ4;
  squash_if    sq4 ();

  fetch_data_t f3, d3o;
  logic        v3, r3, dv3, dr3, ov3;
  logic [1:0]  occ3;
  squash_if    sq3 ();

  fetch_queue #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .fetch_i(f4), .fetch_i_valid(v4), .fetch_i_ready(r4),
    .dec_o(d4o), .dec_o_valid(dv4), .dec_o_ready(dr4),
    .occupancy(occ4), .overflow(ov4), .squash_io(sq4)
  );

  fetch_queue #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .fetch_i(f3), .fetch_i_valid(v3), .fetch_i_ready(r3),
    .dec_o(d3o), .dec_o_valid(dv3), .dec_o_ready(dr3),
    .occupancy(occ3), .overflow(ov3), .squash_io(sq3)
  );

  typedef struct {
    logic        r, s, v;
    logic [31:0] pc;
    logic        d;
    logic        ev;
    logic [31:0] epc;
    int          eocc;
    logic        erdy;
    logic        eovf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp3[$];
  int          checks = 0;
  int          errors = 0;
  int          row    = 0;

  function automatic fetch_data_t mk(input logic [31:0] pc);
    fetch_data_t b;
    b.pc        = pc;
    b.bp.taken  = pc[2];
    b.bp.target = pc + 32'h40;
    b.data      = pc ^ 32'hA5A5_0000;
    return b;
  endfunction

  function automatic vec_t rw(input logic r, input logic s, input logic v, input logic [31:0] pc,
                              input logic d, input logic ev, input logic [31:0] epc, input int eocc,
                              input logic erdy, input logic eovf);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.pc = pc; x.d = d;
    x.ev = ev; x.epc = epc; x.eocc = eocc; x.erdy = erdy; x.eovf = eovf;
    return x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  initial begin
    int issued, sent, got;
    logic inflight;

    // r  s  v  pc            d  | ev epc           occ rdy ovf
    vecs.push_back(rw(0,0,1,32'h8000_0000,1, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h8000_0004,1, 1,32'h8000_0000,  1,1,0));
    vecs.push_back(rw(0,0,1,32'h8000_0008,1, 1,32'h8000_0004,  1,1,0));
    vecs.push_back(rw(0,0,0,32'h0,        1, 1,32'h8000_0008,  1,1,0));
    vecs.push_back(rw(0,0,0,32'h0,        0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h100,      0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h104,      0, 1,32'h100,        1,1,0));
    vecs.push_back(rw(0,0,1,32'h108,      0, 1,32'h100,        2,1,0));
    vecs.push_back(rw(0,0,1,32'h10C,      0, 1,32'h100,        3,0,0));
    vecs.push_back(rw(0,0,1,32'h110,      1, 1,32'h100,        4,0,0));
    vecs.push_back(rw(0,0,0,32'h0,        0, 1,32'h104,        4,0,0));
    vecs.push_back(rw(0,0,0,32'h0,        1, 1,32'h104,        4,0,0));
    vecs.push_back(rw(0,0,0,32'h0,        1, 1,32'h108,        3,0,0));
    vecs.push_back(rw(0,0,0,32'h0,        1, 1,32'h10C,        2,1,0));
    vecs.push_back(rw(0,0,0,32'h0,        1, 1,32'h110,        1,1,0));
    vecs.push_back(rw(0,0,0,32'h0,        0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h1A0,      0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h1A4,      0, 1,32'h1A0,        1,1,0));
    vecs.push_back(rw(0,0,1,32'h1A8,      0, 1,32'h1A0,        2,1,0));
    vecs.push_back(rw(0,1,1,32'h200,      1, 1,32'h1A0,        3,0,0));
    vecs.push_back(rw(0,0,1,32'h300,      0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,0,32'h0,        1, 1,32'h300,        1,1,0));
    vecs.push_back(rw(0,0,0,32'h0,        0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h400,      0, 0,32'h0,          0,1,0));
    vecs.push_back(rw(0,0,1,32'h404,      0, 1,32'h400,        1,1,0));
    vecs.push_back(rw(0,0,1,32'h408,      0, 1,32'h400,        2,1,0));
    vecs.push_back(rw(0,0,1,32'h40C,      0, 1,32'h400,        3,0,0));
    vecs.push_back(rw(0,0,1,32'h410,      0, 1,32'h400,        4,0,0));
    vecs.push_back(rw(0,0,1,32'h414,      0, 1,32'h400,        4,0,1));
    vecs.push_back(rw(0,1,0,32'h0,        0, 1,32'h400,        4,0,1));
    vecs.push_back(rw(0,0,1,32'h420,      0, 0,32'h0,          0,1,1));
    vecs.push_back(rw(1,1,1,32'h500,      0, 1,32'h420,        1,1,1));
    vecs.push_back(rw(0,0,0,32'h0,        0, 0,32'h0,          0,1,0));

    rst = 1'b1;
    v4 = 1'b0; dr4 = 1'b0; f4 = mk(32'h0); sq4.valid = 1'b0;
    v3 = 1'b0; dr3 = 1'b0; f3 = mk(32'h0); sq3.valid = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      row       = i;
      rst       = vecs[i].r;
      sq4.valid = vecs[i].s;
      v4        = vecs[i].v;
      f4        = mk(vecs[i].pc);
      dr4       = vecs[i].d;
      #1;
      chk("dec_o_valid", 128'(dv4), 128'(vecs[i].ev));
      if (vecs[i].ev) chk("dec_o", 128'(d4o), 128'(mk(vecs[i].epc)));
      chk("occupancy", 128'(occ4), 128'(vecs[i].eocc));
      chk("fetch_i_ready", 128'(r4), 128'(vecs[i].erdy));
      chk("overflow", 128'(ov4), 128'(vecs[i].eovf));
    end

    // DEPTH=3: fetch issues whenever ready, beat lands next cycle; decode ready toggles.
    row = 1000;
    issued = 0; sent = 0; got = 0; inflight = 1'b0;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      @(negedge clk);
      v3 = inflight;
      if (inflight) begin
        f3 = mk(32'h1000 + 32'(sent) * 4);
        exp3.push_back(32'h1000 + 32'(sent) * 4);
        sent++;
      end
      dr3 = cyc[0];
      #1;
      if (dv3 && dr3) begin
        if (exp3.size() == 0) begin
          chk("d3_spurious_pop", 128'(d3o), 128'(0));
        end else begin
          chk("d3_order", 128'(d3o), 128'(mk(exp3[0])));
          void'(exp3.pop_front());
        end
        got++;
      end
      inflight = (issued < 20) && r3;
      if (inflight) issued++;
    end
    @(negedge clk);
    v3 = 1'b0; dr3 = 1'b0;
    chk("d3_drained", 128'(got), 128'(20));
    chk("d3_overflow", 128'(ov3), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction buffer between the fetch stage and decode. It captures every `fetch_data_t` beat (pc, branch prediction, 32-bit instruction word) the fetch stage produces and presents them to decode in order through a valid/ready handshake. The fetch stage's output valid ignores backpressure, so this queue reserves room for the beat already in flight. It flushes completely on a squash.

## Interface
- `DEPTH`, default 4: number of entries. Legal range is 2..16; any integer, not only powers of two.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `fetch_i` in `$bits(fetch_data_t)`: beat from fetch (pc, bp, data).
- `fetch_i_valid` in 1: beat present. Must be accepted unconditionally.
- `fetch_i_ready` out 1: permission for fetch to emit a new cache request this cycle.
- `dec_o` out `$bits(fetch_data_t)`: head entry.
- `dec_o_valid` out 1: head entry valid.
- `dec_o_ready` in 1: decode consumes the head.
- `occupancy` out `$clog2(DEPTH+1)`: current entry count.
- `overflow` out 1: sticky error flag. Set when a beat is dropped for lack of space.
- `squash_io` `squash_if.slave`: only `valid` is used. `valid` = flush.

## Operation
- Storage is a circular buffer of `DEPTH` `fetch_data_t` entries with write pointer `wr_ptr`, read pointer `rd_ptr` and counter `count`.
  - Pointers wrap from `DEPTH-1` to 0 by explicit compare, not modulo 2^n.
- Push condition: `fetch_i_valid && !squash_io.valid && (count < DEPTH || pop)`.
  - On push, write `mem[wr_ptr]` and advance `wr_ptr`.
- Pop condition: `dec_o_valid && dec_o_ready && !squash_io.valid`.
  - On pop, advance `rd_ptr`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged. This is legal when full: the slot freed by the pop is reused.
- `dec_o = mem[rd_ptr]`; `dec_o_valid = (count != 0)`. There is no bypass: an empty queue shows nothing the cycle a beat arrives.
- `fetch_i_ready = (count <= DEPTH-2)`.
  - This guarantees space for both the beat arriving this cycle and the beat requested this cycle, which arrives next cycle.
  - It is combinational from `count` only, with no dependence on `dec_o_ready`.
- Overflow: `fetch_i_valid && !squash_io.valid && count == DEPTH && !pop`.
  - The beat is dropped and `overflow` is set to 1.
  - `overflow` holds until reset. This is a protocol violation and must never occur with a compliant fetch stage.
- Squash (`squash_io.valid == 1`):
  - Next cycle: `count = 0`, `wr_ptr = rd_ptr = 0`.
  - A beat arriving in the same cycle is discarded without setting `overflow`.
  - No pop is reported that cycle.
  - Storage contents are not cleared.
- `occupancy = count`.

## Timing
- Reset values: `count = 0`, pointers 0, `overflow = 0`, `dec_o_valid = 0`, `fetch_i_ready = 1`. `dec_o` is don't-care while `dec_o_valid = 0`.
- Reset mid-operation behaves identically to a squash and also clears `overflow`. Reset has priority over squash.
- Latency: a beat pushed at edge t is visible on `dec_o` with `dec_o_valid = 1` in cycle t+1. The minimum fetch-to-decode transit through the queue is one cycle.
- Throughput: one push and one pop per cycle sustained.
- Squash in cycle t: `dec_o_valid = 0` from cycle t+1. A beat arriving in cycle t+1 is accepted normally.
  - Fetch itself marks the request issued during the squash cycle as killed, so that beat never asserts valid.
- `fetch_i_ready` drops in the cycle `count` reaches `DEPTH-1`. The at most one beat already in flight is then always absorbed, so `count` ≤ `DEPTH`.

## Test plan
- Reset, then push pc 0x8000_0000, 0x8000_0004, 0x8000_0008 with `dec_o_ready = 1`.
  - Required: each pc appears on `dec_o` one cycle after its push, in order.
  - Required: `occupancy` never exceeds 1.
- `DEPTH = 4`, `dec_o_ready = 0`, push every cycle while `fetch_i_ready` allows, plus the one in-flight beat.
  - Required: `fetch_i_ready` falls when `occupancy = 3`.
  - Required: the fourth beat is accepted and `occupancy = 4`.
  - Required: `overflow = 0`.
- Full queue (4 entries, pc 0x100..0x10C), push pc 0x110 and pop in the same cycle.
  - Required: `occupancy` stays 4, the head becomes 0x104, and pc 0x110 is later drained last.
- Queue holding 3 entries, assert `squash_io.valid` together with an incoming beat pc 0x200.
  - Required: next cycle `occupancy = 0` and `dec_o_valid = 0`.
  - Required: pc 0x200 never appears on `dec_o`.
  - Required: the next beat pc 0x300 is output first.
- `DEPTH = 3`, run 20 pushes and pops with `dec_o_ready` toggling every cycle.
  - Required: output order equals input order across pointer wrap.
  - Required: `overflow = 0`.
- Full queue, force `fetch_i_valid` without a pop.
  - Required: `overflow` goes to 1 and stays 1 until `rst` is asserted.
  - Required: `occupancy` stays 4.
